// File: rtl/bounce_emu_pkg.sv
// Shared types and constants for the switch bounce emulator and related stimulus blocks.
package bounce_emu_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      BOUNCE = 1'b1
   } bounce_state_t;

   localparam int unsigned        LFSR_W       = 16;
   localparam logic [LFSR_W-1:0]  LFSR_TAPS    = 16'hB400;
   localparam logic [LFSR_W-1:0]  DEFAULT_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_prng.sv
// Free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1); a zero seed is replaced by 1.
module lfsr_prng
   import bounce_emu_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] state
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] seed_safe;

   assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;
   assign lfsr_d    = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         lfsr_q <= seed_safe;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/switch_bounce_emulator.sv
// Turns a clean switch level into a bouncing waveform: immediate first edge,
// pseudo-random glitches for 2^N cycles after the last change, then a clean settle.
module switch_bounce_emulator
   import bounce_emu_pkg::*;
#(
   parameter int unsigned       N        = 3,
   parameter int unsigned       GLITCH_W = 2,
   parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED
) (
   input  logic clk,
   input  logic reset,
   input  logic en,
   input  logic sw_clean,
   output logic sw_bouncy,
   output logic bouncing,
   output logic settle_tick
);

   localparam int unsigned GL_W     = GLITCH_W + 1;
   localparam logic [N-1:0] WIN_LOAD = '1;

   bounce_state_t     state_q, state_d;
   logic              level_q, level_d;
   logic              bouncy_q, bouncy_d;
   logic              settle_q, settle_d;
   logic [N-1:0]      win_q, win_d;
   logic [GL_W-1:0]   gl_q, gl_d;
   logic [LFSR_W-1:0] lfsr;
   logic [GL_W-1:0]   g;
   logic              chg;
   logic              win_last;
   logic              gl_last;
   logic              unused_lfsr_hi;

   lfsr_prng u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (SEED),
      .state (lfsr)
   );

   assign g              = GL_W'(lfsr[GLITCH_W-1:0]) + GL_W'(1);
   assign unused_lfsr_hi = ^lfsr[LFSR_W-1:GLITCH_W];
   assign chg            = (sw_clean != level_q);
   assign win_last       = (win_q == N'(1));
   assign gl_last        = (gl_q == GL_W'(1));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         level_q  <= 1'b0;
         bouncy_q <= 1'b0;
         settle_q <= 1'b0;
         win_q    <= '0;
         gl_q     <= '0;
      end else begin
         state_q  <= state_d;
         level_q  <= level_d;
         bouncy_q <= bouncy_d;
         settle_q <= settle_d;
         win_q    <= win_d;
         gl_q     <= gl_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      level_d  = level_q;
      bouncy_d = bouncy_q;
      settle_d = 1'b0;
      win_d    = win_q;
      gl_d     = gl_q;

      if (!en) begin
         state_d  = IDLE;
         level_d  = sw_clean;
         bouncy_d = sw_clean;
         win_d    = '0;
         gl_d     = '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (chg) begin
                  level_d  = sw_clean;
                  bouncy_d = sw_clean;
                  win_d    = WIN_LOAD;
                  gl_d     = g;
                  state_d  = BOUNCE;
               end
            end
            BOUNCE: begin
               win_d = win_q - N'(1);
               gl_d  = gl_q - GL_W'(1);
               if (gl_last) begin
                  bouncy_d = ~bouncy_q;
                  gl_d     = g;
               end
               // A new edge restarts the window and outranks the settle on the last cycle.
               if (chg) begin
                  level_d = sw_clean;
                  win_d   = WIN_LOAD;
               end else if (win_last) begin
                  bouncy_d = level_q;
                  state_d  = IDLE;
                  settle_d = 1'b1;
                  win_d    = '0;
                  gl_d     = '0;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign sw_bouncy   = bouncy_q;
   assign bouncing    = (state_q == BOUNCE);
   assign settle_tick = settle_q;

endmodule
